// File: rtl/pe_skew_scheduler_pkg.sv
// Shared types and defaults for the PE skew scheduler.
// Contents: FSM state enum, default geometry, lane-slice helper for packed lane buses.
package pe_sched_pkg;

  localparam int unsigned DefRows    = 8;
  localparam int unsigned DefDataW   = 16;
  localparam int unsigned DefMaxK    = 8;
  localparam int unsigned DefTimeout = 64;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StStream,
    StDrain,
    StFin
  } state_e;

  // LSB of lane `lane` in a bus of lanes packed `width` bits apart.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/pe_skew_scheduler_if.sv
// Scheduler <-> pe_8x8_cluster bus.
// master (scheduler): drives pe_en, pe_rst_n, pe_act, pe_wgt, pe_done;
//                     samples pe_out_done, pe_results.
// slave  (cluster):   the reverse.
interface pe_skew_scheduler_if #(
  parameter int unsigned ROWS   = 8,
  parameter int unsigned DATA_W = 16
);
  logic                     pe_en;
  logic                     pe_rst_n;
  logic [ROWS*DATA_W-1:0]   pe_act;
  logic [ROWS*DATA_W-1:0]   pe_wgt;
  logic [ROWS-1:0]          pe_done;
  logic [ROWS-1:0]          pe_out_done;
  logic [ROWS*DATA_W-1:0]   pe_results;

  modport master (
    output pe_en, pe_rst_n, pe_act, pe_wgt, pe_done,
    input  pe_out_done, pe_results
  );

  modport slave (
    input  pe_en, pe_rst_n, pe_act, pe_wgt, pe_done,
    output pe_out_done, pe_results
  );
endinterface

// File: rtl/pe_skew_lane.sv
// Per-row skew decode.
// Inputs : s (stream cycle), row (lane index), k_len (elements per row).
// Outputs: idx (buffer element for this cycle), valid (lane carries data),
//          done_set (this is the cycle the row's done flag rises).
module pe_skew_lane #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned MAX_K = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic [CNT_W-1:0]         s,
  input  logic [$clog2(ROWS)-1:0]  row,
  input  logic [$clog2(MAX_K):0]   k_len,
  output logic [$clog2(MAX_K)-1:0] idx,
  output logic                     valid,
  output logic                     done_set
);
  localparam int unsigned IW = $clog2(MAX_K);

  // One extra bit so row + k_len never wraps.
  logic [CNT_W:0] s_ext, row_ext, end_ext;

  always_comb begin
    s_ext    = {1'b0, s};
    row_ext  = (CNT_W+1)'(row);
    end_ext  = row_ext + (CNT_W+1)'(k_len);
    valid    = (s_ext >= row_ext) && (s_ext < end_ext);
    done_set = (s_ext == end_ext);
    idx      = IW'(s_ext - row_ext);
  end
endmodule

// File: rtl/pe_skew_scheduler.sv
// Tile sequencer in front of pe_8x8_cluster.
// Load port (ld_*) fills a ROWS x MAX_K act/wgt buffer while idle. start/k_len launch a
// tile: CLEAR the cluster, STREAM rows with one cycle of skew per row plus a sticky done
// flag, DRAIN until the last row reports done (or TIMEOUT), FIN captures results.
// Status: ld_ready, busy, done (pulse), err (pulse), result (held).
// Cluster side via pe_skew_scheduler_if.master. All outputs registered.
module pe_skew_scheduler
  import pe_sched_pkg::*;
#(
  parameter int unsigned ROWS    = DefRows,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned MAX_K   = DefMaxK,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_valid,
  input  logic [$clog2(ROWS)-1:0]    ld_row,
  input  logic [$clog2(MAX_K)-1:0]   ld_k,
  input  logic [DATA_W-1:0]          ld_act,
  input  logic [DATA_W-1:0]          ld_wgt,
  output logic                       ld_ready,
  input  logic                       start,
  input  logic [$clog2(MAX_K):0]     k_len,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [ROWS*DATA_W-1:0]     result,
  pe_skew_scheduler_if.master        pe
);
  localparam int unsigned RW  = $clog2(ROWS);
  localparam int unsigned KIW = $clog2(MAX_K);
  localparam int unsigned KW  = KIW + 1;
  localparam int unsigned CW  = $clog2(ROWS + MAX_K + TIMEOUT + 1);

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [KW-1:0]          k_len_q;
  logic                   busy_q, done_q, err_q, ld_ready_q;
  logic [ROWS*DATA_W-1:0] result_q;
  logic                   pe_en_q, pe_rst_n_q;
  logic [ROWS*DATA_W-1:0] pe_act_q, pe_wgt_q;
  logic [ROWS-1:0]        pe_done_q;

  logic [DATA_W-1:0] act_buf [ROWS][MAX_K];
  logic [DATA_W-1:0] wgt_buf [ROWS][MAX_K];

  logic [CW-1:0]          s_nxt, last_s;
  logic [ROWS*DATA_W-1:0] act_nxt, wgt_nxt;
  logic [ROWS-1:0]        done_set;
  logic                   kl_ok, ld_ok;
  logic [RW:0]            ld_row_ext;
  logic [KIW:0]           ld_k_ext;
  logic                   unused_out_done;

  assign unused_out_done = ^pe.pe_out_done[ROWS-2:0];

  always_comb begin
    // Outputs are registered, so lanes decode the stream cycle that follows this one.
    s_nxt      = (state_q == StStream) ? cnt_q + CW'(1) : '0;
    last_s     = CW'(ROWS) + CW'(k_len_q) - CW'(1);
    kl_ok      = (k_len != '0) && (k_len <= KW'(MAX_K));
    ld_row_ext = {1'b0, ld_row};
    ld_k_ext   = {1'b0, ld_k};
    ld_ok      = (ld_row_ext < (RW+1)'(ROWS)) && (ld_k_ext < (KIW+1)'(MAX_K));
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [KIW-1:0] idx;
    logic           valid;

    pe_skew_lane #(
      .ROWS  (ROWS),
      .MAX_K (MAX_K),
      .CNT_W (CW)
    ) u_lane (
      .s        (s_nxt),
      .row      (RW'(r)),
      .k_len    (k_len_q),
      .idx      (idx),
      .valid    (valid),
      .done_set (done_set[r])
    );

    assign act_nxt[lane_lsb(r, DATA_W) +: DATA_W] = valid ? act_buf[r][idx] : '0;
    assign wgt_nxt[lane_lsb(r, DATA_W) +: DATA_W] = valid ? wgt_buf[r][idx] : '0;
  end

  // Buffer has no reset; contents survive rst and tiles.
  always_ff @(posedge clk) begin
    if (!rst && state_q == StIdle && ld_valid && ld_ok) begin
      act_buf[ld_row][ld_k] <= ld_act;
      wgt_buf[ld_row][ld_k] <= ld_wgt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      k_len_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ld_ready_q <= 1'b0;
      result_q   <= '0;
      pe_en_q    <= 1'b0;
      pe_rst_n_q <= 1'b1;
      pe_act_q   <= '0;
      pe_wgt_q   <= '0;
      pe_done_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ld_ready_q <= 1'b1;
          if (start && !kl_ok) begin
            err_q <= 1'b1;
          end else if (start) begin
            state_q    <= StClear;
            k_len_q    <= k_len;
            busy_q     <= 1'b1;
            ld_ready_q <= 1'b0;
            pe_en_q    <= 1'b1;
            pe_rst_n_q <= 1'b0;
            pe_act_q   <= '0;
            pe_wgt_q   <= '0;
            pe_done_q  <= '0;
          end
        end
        StClear: begin
          state_q    <= StStream;
          cnt_q      <= '0;
          pe_rst_n_q <= 1'b1;
          pe_act_q   <= act_nxt;
          pe_wgt_q   <= wgt_nxt;
          pe_done_q  <= pe_done_q | done_set;
        end
        StStream: begin
          if (cnt_q == last_s) begin
            state_q   <= StDrain;
            cnt_q     <= '0;
            pe_act_q  <= '0;
            pe_wgt_q  <= '0;
            pe_done_q <= '1;
          end else begin
            cnt_q     <= cnt_q + CW'(1);
            pe_act_q  <= act_nxt;
            pe_wgt_q  <= wgt_nxt;
            pe_done_q <= pe_done_q | done_set;
          end
        end
        StDrain: begin
          if (pe.pe_out_done[ROWS-1]) begin
            state_q   <= StFin;
            pe_en_q   <= 1'b0;
            pe_done_q <= '0;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q    <= StIdle;
            err_q      <= 1'b1;
            busy_q     <= 1'b0;
            ld_ready_q <= 1'b1;
            pe_en_q    <= 1'b0;
            pe_done_q  <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        StFin: begin
          state_q    <= StIdle;
          result_q   <= pe.pe_results;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          ld_ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ld_ready    = ld_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign result      = result_q;
  assign pe.pe_en    = pe_en_q;
  assign pe.pe_rst_n = pe_rst_n_q;
  assign pe.pe_act   = pe_act_q;
  assign pe.pe_wgt   = pe_wgt_q;
  assign pe.pe_done  = pe_done_q;
endmodule

// File: doc/pe_skew_scheduler.md
Name: pe_skew_scheduler

Overview:
- Sequencer in front of pe_8x8_cluster.
- Holds one tile of activations and weights in an internal ROWS x MAX_K buffer, filled through a serial load port.
- On start, clears the cluster, then streams each row into it with a one-cycle skew per row, followed by that row's done flag.
- Waits for the cluster's last-row done, captures results and signals completion. Replaces hand-written skew logic in benches and top level.

Parameters:
- ROWS, 8, cluster rows/lanes.
- DATA_W, 16, activation/weight/result lane width.
- MAX_K, 8, maximum stream length per row (buffer depth).
- TIMEOUT, 64, maximum DRAIN cycles before error.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ld_valid  in  1  load strobe
- ld_row  in  $clog2(ROWS)  load row index
- ld_k  in  $clog2(MAX_K)  load element index
- ld_act  in  DATA_W  activation value
- ld_wgt  in  DATA_W  weight value
- ld_ready  out  1  high only in IDLE
- start  in  1  begin a tile
- k_len  in  $clog2(MAX_K)+1  elements per row, sampled at start
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse: bad k_len or timeout
- result  out  ROWS*DATA_W  captured cluster results, held until next accepted start
- pe_en  out  1  cluster enable
- pe_rst_n  out  1  cluster reset (active-low)
- pe_act  out  ROWS*DATA_W  activations to cluster, row r at [r*DATA_W +: DATA_W]
- pe_wgt  out  ROWS*DATA_W  weights to cluster, same packing as pe_act
- pe_done  out  ROWS  per-row done to cluster
- pe_out_done  in  ROWS  output_dones from cluster
- pe_results  in  ROWS*DATA_W  results from cluster

Behaviour:
- All outputs registered.
- Reset values:
  - state = IDLE; busy = done = err = 0; result = 0.
  - pe_en = 0; pe_rst_n = 1; pe_act = pe_wgt = 0; pe_done = 0.
  - ld_ready = 1 from the cycle after reset deasserts.
  - Buffer is not reset.
- Load:
  - In IDLE, ld_valid writes buf[ld_row][ld_k] at the edge.
  - In any other state, ld_valid is ignored.
  - Out-of-range ld_row or ld_k is ignored.
- State machine IDLE -> CLEAR -> STREAM -> DRAIN -> FIN -> IDLE.
- IDLE:
  - start with 1 <= k_len <= MAX_K: latch k_len and go to CLEAR.
  - start with k_len = 0 or k_len > MAX_K: err pulse next cycle, stay in IDLE.
  - start is ignored outside IDLE.
  - If start and ld_valid arrive in the same IDLE cycle, the load is performed and start is accepted.
- CLEAR: exactly 1 cycle; pe_rst_n = 0, pe_en = 1, lane data = 0, pe_done = 0.
- STREAM: lasts ROWS + k_len cycles, s = 0 .. ROWS + k_len - 1; pe_en = 1. For row r in cycle s:
  - r <= s < r + k_len: pe_act[r] = buf act[r][s-r], pe_wgt[r] = buf wgt[r][s-r].
  - s == r + k_len: lane data = 0; pe_done[r] rises and stays high (sticky) until FIN.
  - Otherwise: lane data = 0.
  - Net effect: row 0 outputs its first data in the cycle after CLEAR, and each row is exactly one cycle behind the previous one.
  - The last STREAM cycle is the one where pe_done[ROWS-1] first rises.
- DRAIN: lane data = 0, pe_en = 1, pe_done held at all-ones.
  - Counter runs from 0. When pe_out_done[ROWS-1] is seen high, go to FIN.
  - If the counter reaches TIMEOUT first: err pulse, go to IDLE. result is unchanged, pe_done is cleared, pe_en = 0.
  - pe_out_done[ROWS-1] already high on DRAIN entry is accepted immediately.
- FIN: 1 cycle.
  - result <= pe_results sampled at the FIN edge.
  - done pulses during the cycle after FIN (IDLE).
  - pe_done cleared, pe_en = 0.
- busy is high throughout CLEAR, STREAM, DRAIN and FIN.
- rst mid-operation: return to the reset values at the next edge and abandon the tile. No done or err pulse. pe_rst_n stays 1.
- k_len = MAX_K: s reaches ROWS + MAX_K - 1. The counter is sized to hold ROWS + MAX_K + TIMEOUT without wrap.

Decomposition:
- Package pe_sched_pkg: state enum (IDLE, CLEAR, STREAM, DRAIN, FIN); default ROWS, DATA_W and MAX_K localparams; lane-slice helper function.
- Sub-module pe_skew_lane: one per row, generate-instantiated. Inputs s, k_len and row index. Outputs the buffer index, data-valid and done-set flags for that lane.

Test Plan:
- Load act[r][k] = 16*r + k and wgt[r][k] = 0x100 + 16*r + k, k_len = 4, start.
  - Required: row 0 emits 0x00..0x03 in stream cycles 0–3 and pe_done[0] rises in cycle 4.
  - Required: row 7 emits 0x70..0x73 in cycles 7–10 and pe_done[7] rises in cycle 11.
  - Required: all other lane values are 0.
- Cluster model asserts pe_out_done[7] 3 cycles into DRAIN with pe_results = 0x1234 in every lane -> result = {8{0x1234}}, one done pulse, busy falls, ld_ready = 1.
- start with k_len = 0, then start with k_len = 9 -> err pulse each time, state stays IDLE, pe_en stays 0, result unchanged.
- pe_out_done never asserted -> err pulse after exactly 64 DRAIN cycles, return to IDLE, no done pulse.
- rst asserted in STREAM cycle 5 -> next cycle all pe_* outputs and busy are at reset values. A new start with k_len = 1 then runs STREAM for 9 cycles.
- ld_valid during STREAM with ld_row = 0, ld_k = 0, value 0xFFFF -> buffer unchanged. A second tile replays the original 0x00 on row 0.
